// File: rtl/scan_sequencer.sv
// KITT-style bounce scanner: two-stage prescaler with four speeds, run/hold/clear
// control, and a registered one-hot LED drive that follows the scan position.
module scan_sequencer #(
  parameter int NUM_LEDS = 8,
  parameter int BASE_DIV = 250000,
  parameter int POS_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                speed_btn,
  input  logic                clr,
  output logic [NUM_LEDS-1:0] led_out,
  output logic [POS_W-1:0]    pos_out,
  output logic                dir_out,
  output logic [1:0]          speed_sel,
  output logic                step_tick,
  output logic                busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam int              BASE_W   = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(BASE_DIV - 1);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(NUM_LEDS - 1);

  logic [1:0]        state;
  logic [BASE_W-1:0] base_cnt;
  logic [1:0]        step_cnt;
  logic              btn_prev;

  logic              running;
  logic              base_tick;
  logic              step;
  logic [POS_W-1:0]  step_pos;
  logic              step_dir;

  assign running   = (state == S_UP) || (state == S_DOWN);
  assign base_tick = running && (base_cnt == BASE_LAST);
  // >= so that a faster speed selected mid-count steps at the next base tick.
  assign step      = base_tick && (step_cnt >= (2'd3 - speed_sel));

  always_comb begin
    step_pos = pos_out;
    step_dir = dir_out;
    if (!dir_out) begin
      if (pos_out < POS_LAST) begin
        step_pos = pos_out + POS_W'(1);
      end else begin
        step_dir = 1'b1;
        step_pos = POS_LAST - POS_W'(1);
      end
    end else begin
      if (pos_out != '0) begin
        step_pos = pos_out - POS_W'(1);
      end else begin
        step_dir = 1'b0;
        step_pos = POS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      base_cnt  <= '0;
      step_cnt  <= '0;
      btn_prev  <= 1'b1;
      led_out   <= '0;
      pos_out   <= '0;
      dir_out   <= 1'b0;
      speed_sel <= 2'd0;
      step_tick <= 1'b0;
      busy      <= 1'b0;
    end else begin
      btn_prev  <= speed_btn;
      step_tick <= 1'b0;
      if (speed_btn && !btn_prev) begin
        speed_sel <= speed_sel + 2'd1;
      end

      if (clr) begin
        state    <= S_IDLE;
        base_cnt <= '0;
        step_cnt <= '0;
        led_out  <= '0;
        pos_out  <= '0;
        dir_out  <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (run) begin
              state    <= S_UP;
              base_cnt <= '0;
              step_cnt <= '0;
              pos_out  <= '0;
              dir_out  <= 1'b0;
              led_out  <= NUM_LEDS'(1);
              busy     <= 1'b1;
            end
          end
          S_UP, S_DOWN: begin
            if (!run) begin
              // Dropping run wins over a coincident step; counters freeze.
              state <= S_HOLD;
              busy  <= 1'b0;
            end else begin
              base_cnt <= base_tick ? '0 : base_cnt + BASE_W'(1);
              if (base_tick) begin
                step_cnt <= step ? 2'd0 : step_cnt + 2'd1;
              end
              if (step) begin
                step_tick <= 1'b1;
                pos_out   <= step_pos;
                dir_out   <= step_dir;
                state     <= step_dir ? S_DOWN : S_UP;
                led_out   <= NUM_LEDS'(1) << step_pos;
              end
            end
          end
          default: begin
            if (run) begin
              state <= dir_out ? S_DOWN : S_UP;
              busy  <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Sequences the KITT-style LED scanner from debounced button levels produced upstream by the debouncer instances.
- Generates the scan step timing from a two-stage prescaler with four selectable speeds.
- Runs a bounce-scan position FSM (0 to NUM_LEDS-1 and back) and drives a one-hot LED vector.
- Supports run/hold, synchronous clear and speed cycling.

Parameters:
- NUM_LEDS, 8, number of scanner LEDs (legal range 2..16).
- BASE_DIV, 250000, clk cycles per base tick (25 ms at 10 MHz); bench uses 4.
- POS_W, 4, width of pos_out; must be at least clog2(NUM_LEDS).

Ports:
- clk  input  1  system clock (10 MHz).
- rst_n  input  1  reset; asynchronous, active-low.
- run  input  1  debounced level; 1 = scan, 0 = hold.
- speed_btn  input  1  debounced level; each rising edge advances the speed.
- clr  input  1  synchronous clear back to IDLE.
- led_out  output  NUM_LEDS  one-hot LED drive.
- pos_out  output  POS_W  current scan position.
- dir_out  output  1  0 = moving up, 1 = moving down.
- speed_sel  output  2  current speed; 0 = slowest.
- step_tick  output  1  one-cycle pulse on each position change.
- busy  output  1  high in UP or DOWN.

Behaviour:
- Clock and reset: clk is the clock; rst_n is asynchronous, active-low. All outputs are registered.
- Reset values:
  - state IDLE.
  - pos_out, dir_out, speed_sel, step_tick, busy = 0.
  - led_out = 0.
  - base and step counters = 0.
  - speed_btn edge register = 1, so a button held high through reset release does not count as a press.
- Speed:
  - A rising edge is speed_btn=1 with prev=0.
  - On each rising edge, speed_sel <= speed_sel+1 mod 4 (3 wraps to 0). This applies in any state.
  - Step period = BASE_DIV*(4-speed_sel) clocks: speed 0 = 4 base ticks, speed 3 = 1 base tick.
- Prescaler:
  - The base counter counts 0..BASE_DIV-1 only in UP or DOWN; base_tick occurs at BASE_DIV-1, then the counter wraps to 0.
  - On base_tick, if step_cnt >= 3-speed_sel, a step fires and step_cnt <= 0; otherwise step_cnt increments.
  - Using >= means lowering the limit mid-count steps at the next base tick.
  - Both counters freeze in HOLD and are cleared on entry to IDLE.
- FSM states: IDLE, UP, DOWN, HOLD.
  - IDLE -> UP when run=1. Counters are at 0 and pos=0.
  - UP, step: if pos < NUM_LEDS-1 then pos+1; else state DOWN, dir=1, pos <= NUM_LEDS-2.
  - DOWN, step: if pos > 0 then pos-1; else state UP, dir=0, pos <= 1.
  - Resulting sequence for N=8: 0,1..7,6..0,1..; endpoints are shown once, with no dwell.
  - UP/DOWN -> HOLD when run=0. pos, dir and counters freeze.
  - HOLD -> UP if dir=0, or DOWN if dir=1, when run=1. The remaining period resumes from the frozen count.
  - clr=1 in any state -> IDLE next cycle: pos=0, dir=0, counters=0. clr has priority over run and over a coincident step. speed_sel is unaffected by clr.
- Outputs:
  - step_tick is asserted on the same clock edge that updates pos (registered, one cycle wide).
  - led_out = 1<<pos in UP/DOWN/HOLD; led_out = 0 in IDLE. It is registered alongside pos, so an LED is lit the cycle after IDLE->UP.
  - busy = 1 exactly when the state is UP or DOWN.
- Simultaneous events:
  - If run falls on the same cycle a step fires, the step is suppressed; HOLD takes priority.
  - A speed press coincident with a step takes effect from the next base tick.

Test Plan (BASE_DIV=4, NUM_LEDS=8):
- Reset, hold run=1 from cycle 0 -> led_out=0x01 one cycle after reset release; first step_tick 16 cycles later with pos=1 and led_out=0x02; busy=1.
- Free run at speed 0 -> pos sequence 0..7,6..0,1; dir_out toggles at pos 7 and pos 0; exactly 14 step_ticks per 224 cycles.
- Three speed_btn pulses -> speed_sel=3 and step period 4 cycles; fourth pulse -> speed_sel=0 and period 16; speed_btn held high through reset causes no increment.
- Drop run at pos=5 with dir=1, 6 cycles into the period -> HOLD with led_out=0x20 frozen and no step_tick; reassert run -> next step after 10 cycles to pos=4.
- Assert clr together with run=1 on a step cycle -> next cycle IDLE with led_out=0, pos=0, no step_tick, speed_sel retained.
- Assert rst_n low mid-scan asynchronously -> all outputs 0 immediately; restart behaves as in scenario 1.
